// File: rtl/music_note_sequencer.sv
// music_note_sequencer: plays a score held in an internal RAM, one entry per note.
// Each entry is {last, duration[5:0] beats, select[5:0]}; a note sounds for
// duration*BEAT_DIV - GAP_CYCLES cycles followed by a GAP_CYCLES silent gap.
// Build option: define MUSIC_SEQ_LOOP_EN to replay the score from address 0
// at the end instead of returning to idle with a done pulse.
// GAP_CYCLES is expected to be at least 1 and below BEAT_DIV.
module music_note_sequencer #(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned BEAT_DIV   = 25000000,
   parameter int unsigned GAP_CYCLES = 2500000,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [12:0]   wr_data,
   input  logic          start,
   input  logic          stop,
   output logic [5:0]    select,
   output logic          note_on,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] cur_addr
);

   localparam longint unsigned MAX_CNT = 64'(63) * 64'(BEAT_DIV);
   localparam int unsigned     CW      = 32'($clog2(MAX_CNT + 64'd1));

   typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   addr_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            last_q, last_nxt;
   logic            load_sel_c;
   logic            done_nxt, note_on_nxt, busy_nxt;
   logic [5:0]      select_nxt;
   logic [12:0]     mem [DEPTH];
   logic [12:0]     rd_data;
   logic [5:0]      dur_eff_c;
   logic [CW-1:0]   play_len_c;

   // Zero-beat entries play as one beat; play length excludes the gap.
   always_comb begin
      dur_eff_c  = (rd_data[11:6] == 6'd0) ? 6'd1 : rd_data[11:6];
      play_len_c = CW'(dur_eff_c) * CW'(BEAT_DIV) - CW'(GAP_CYCLES);
   end

   // Score RAM: writes only while idle; read address follows the next address
   // so the entry is already on rd_data during FETCH.
   always_ff @(posedge clk) begin
      if (!reset && wr_en && state == IDLE)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[addr_nxt];
   end

   // State register with address, cycle counter and last-entry flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cur_addr <= '0;
         cnt      <= '0;
         last_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cur_addr <= addr_nxt;
         cnt      <= cnt_nxt;
         last_q   <= last_nxt;
      end
   end

   // Next-state logic: sequencing through the score, stop aborts silently.
   always_comb begin
      state_nxt  = state;
      addr_nxt   = cur_addr;
      cnt_nxt    = cnt;
      last_nxt   = last_q;
      load_sel_c = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_nxt = FETCH;
               addr_nxt  = '0;
            end
         end
         FETCH: begin
            state_nxt  = PLAY;
            cnt_nxt    = play_len_c - CW'(1);
            last_nxt   = rd_data[12];
            load_sel_c = 1'b1;
         end
         PLAY: begin
            if (cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = CW'(GAP_CYCLES - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         GAP: begin
            if (cnt == '0) begin
               if (last_q || cur_addr == AW'(DEPTH - 1)) begin
`ifdef MUSIC_SEQ_LOOP_EN
                  state_nxt = FETCH;
                  addr_nxt  = '0;
`else
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
`endif
               end else begin
                  state_nxt = FETCH;
                  addr_nxt  = cur_addr + AW'(1);
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (stop && state != IDLE) begin
         state_nxt  = IDLE;
         cnt_nxt    = '0;
         load_sel_c = 1'b0;
         done_nxt   = 1'b0;
      end
   end

   // Output decode from the next state; select only changes when a note loads.
   always_comb begin
      note_on_nxt = (state_nxt == PLAY);
      busy_nxt    = (state_nxt != IDLE);
      select_nxt  = load_sel_c ? rd_data[5:0] : select;
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         select  <= '0;
         note_on <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         select  <= select_nxt;
         note_on <= note_on_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

endmodule

// File: doc/music_note_sequencer.md
MUSIC_NOTE_SEQUENCER -- requirements
Module: music_note_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, 32: score RAM entries; address width AW = log2(DEPTH).
REQ-002 SHALL have parameter BEAT_DIV, 25000000: clk cycles per beat.
REQ-003 SHALL have parameter GAP_CYCLES, 2500000: silent articulation cycles at the end of each note; must be less than BEAT_DIV.
REQ-004 SHALL have port clk  in  1  the single system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  in  1  score write strobe.
REQ-007 SHALL have port wr_addr  in  AW  score write address.
REQ-008 SHALL have port wr_data  in  13  score entry: [12] last flag, [11:6] duration in beats, [5:0] note select code.
REQ-009 SHALL have port start  in  1  one-cycle pulse that starts playback from address 0.
REQ-010 SHALL have port stop  in  1  one-cycle pulse that aborts playback.
REQ-011 SHALL have port select  out  6  note/waveform code for the downstream tone generator: [5] waveform, [4:0] note.
REQ-012 SHALL have port note_on  out  1  gate; high only while the note must sound.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse when playback ends naturally.
REQ-015 SHALL have port cur_addr  out  AW  address of the entry being played.

Function
REQ-016 SHALL hold the score in a DEPTH x 13 synchronous-read RAM; contents persist across reset and across plays.
REQ-017 SHALL write wr_data to wr_addr when wr_en=1 and busy=0; while busy=1, writes are ignored.
REQ-018 SHALL use FSM states IDLE, FETCH, PLAY and GAP.
REQ-019 IDLE: on start=1 with stop=0, SHALL go to FETCH next cycle with cur_addr=0.
REQ-020 FETCH: lasts exactly 1 cycle; SHALL then go to PLAY, loading select and the duration from the entry at cur_addr.
REQ-021 A duration field of 0 SHALL be treated as 1 beat.
REQ-022 PLAY: SHALL drive note_on=1 for duration*BEAT_DIV - GAP_CYCLES cycles, then go to GAP.
REQ-023 GAP: SHALL drive note_on=0 for GAP_CYCLES cycles; select holds its value throughout.
REQ-024 At the end of GAP, if the entry's last flag=1 or cur_addr=DEPTH-1, SHALL take the end-of-score action (REQ-035/036); otherwise SHALL increment cur_addr and go to FETCH.
REQ-025 Note period SHALL be 1 + duration*BEAT_DIV cycles, measured from FETCH entry to the next FETCH entry.
REQ-026 note_on SHALL be 0 in IDLE and FETCH.
REQ-027 stop=1 in any non-IDLE state SHALL force IDLE next cycle with note_on=0 and no done pulse; select keeps its last value.
REQ-028 When start and stop are asserted in the same cycle, stop SHALL win.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 All counters SHALL be wide enough for 63*BEAT_DIV without overflow.

Reset
REQ-031 reset=1 SHALL override all other inputs, including start, stop and wr_en.
REQ-032 On reset the state SHALL be IDLE and select=0, note_on=0, busy=0, done=0, cur_addr=0, with all counters at 0.
REQ-033 Reset asserted mid-note SHALL silence the output the following cycle with no done pulse.
REQ-034 Reset SHALL NOT clear RAM contents.

Configuration
REQ-035 With MUSIC_SEQ_LOOP_EN defined, the end-of-score action SHALL set cur_addr=0 and go to FETCH without pulsing done; playback repeats until stop or reset.
REQ-036 Without MUSIC_SEQ_LOOP_EN, the end-of-score action SHALL go to IDLE and pulse done=1 for exactly one cycle, coincident with busy falling to 0.

Verification (BEAT_DIV=4, GAP_CYCLES=1, DEPTH=8)
REQ-037 Load {0,2,0x05}@0 and {1,1,0x25}@1, then start:
- select=0x05 with note_on high for 7 cycles, then low for 1.
- select=0x25 with note_on high for 3 cycles, then low for 1.
- done pulses once; total busy time 1+8+1+4 = 14 cycles.
REQ-038 Duration-0 entry with last=1, start: note_on high for 3 cycles, total busy time 5 cycles.
REQ-039 stop in the 3rd PLAY cycle: busy=0 and note_on=0 on the next cycle, done stays 0; a later start replays from address 0.
REQ-040 start and stop in the same IDLE cycle: busy stays 0. A write of 0x1FFF to addr 0 while busy: RAM is unchanged after playback.
REQ-041 reset mid-GAP: all outputs return to their REQ-032 values next cycle; start again reproduces REQ-037 exactly.
REQ-042 With MUSIC_SEQ_LOOP_EN and the REQ-037 score: after addr 1 the block refetches addr 0, done never pulses, and it runs 3 full loops before stop.
